// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between the processor (C) and a debug/loader
// master (D), routes one-cycle-latency read data back to the issuing port, and lets D lock the port.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic [AW-1:0] c_addr,
    output logic          c_ack,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_locked,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_strobe,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SHARED, LOCK_WAIT, LOCKED} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t        state;
    state_t        nextState;
    logic          cTurn;
    logic [3:0]    cWait;
    logic [3:0]    dWait;
    logic          rdPending;
    logic          rdOwnerD;
    logic [DW-1:0] cRdataHold;
    logic [DW-1:0] dRdataHold;
    logic          cGrant;
    logic          dGrant;
    logic          cWins;
    logic          cRvalidInt;
    logic          dRvalidInt;

    // Contention winner: a starved port (counter at MAX_WAIT) overrides the round-robin turn.
    // C holds the turn out of reset, so the first contended grant goes to C.
    always_comb begin
        cWins = cTurn;
        if ((cWait == WAIT_MAX) && (dWait != WAIT_MAX)) begin
            cWins = 1'b1;
        end else if ((dWait == WAIT_MAX) && (cWait != WAIT_MAX)) begin
            cWins = 1'b0;
        end
    end

    always_comb begin
        cGrant = 1'b0;
        dGrant = 1'b0;
        if (!reset) begin
            case (state)
                IDLE, SHARED: begin
                    if (c_req && d_req) begin
                        cGrant = cWins;
                        dGrant = !cWins;
                    end else begin
                        cGrant = c_req;
                        dGrant = d_req;
                    end
                end
                default: dGrant = d_req;
            endcase
        end
    end

    // LOCK_WAIT never grants C, so the only C read that can still be outstanding there
    // returns in the first LOCK_WAIT cycle; the port is fully drained one cycle later.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (c_req || d_req) nextState = SHARED;
            SHARED: begin
                if (d_lock) begin
                    nextState = LOCK_WAIT;
                end else if (!c_req && !d_req) begin
                    nextState = IDLE;
                end
            end
            LOCK_WAIT: nextState = d_lock ? LOCKED : SHARED;
            LOCKED:    if (!d_lock) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cTurn      <= 1'b1;
            cWait      <= '0;
            dWait      <= '0;
            rdPending  <= 1'b0;
            rdOwnerD   <= 1'b0;
            cRdataHold <= '0;
            dRdataHold <= '0;
        end else begin
            state     <= nextState;
            rdPending <= cGrant || (dGrant && !d_we);
            rdOwnerD  <= dGrant;
            if (cGrant) begin
                cTurn <= 1'b0;
            end else if (dGrant) begin
                cTurn <= 1'b1;
            end
            if (cGrant) begin
                cWait <= '0;
            end else if (c_req && (cWait != WAIT_MAX)) begin
                cWait <= cWait + 4'd1;
            end
            if (dGrant) begin
                dWait <= '0;
            end else if (d_req && (dWait != WAIT_MAX)) begin
                dWait <= dWait + 4'd1;
            end
            if (cRvalidInt) cRdataHold <= mem_rdata;
            if (dRvalidInt) dRdataHold <= mem_rdata;
        end
    end

    assign cRvalidInt = rdPending && !rdOwnerD && !reset;
    assign dRvalidInt = rdPending && rdOwnerD && !reset;

    assign c_ack      = cGrant;
    assign d_ack      = dGrant;
    assign c_rvalid   = cRvalidInt;
    assign d_rvalid   = dRvalidInt;
    assign c_rdata    = reset ? '0 : (cRvalidInt ? mem_rdata : cRdataHold);
    assign d_rdata    = reset ? '0 : (dRvalidInt ? mem_rdata : dRdataHold);
    assign d_locked   = (state == LOCKED) && !reset;
    assign mem_strobe = cGrant || dGrant;
    assign mem_we     = dGrant && d_we;
    assign mem_addr   = cGrant ? c_addr : (dGrant ? d_addr : '0);
    assign mem_wdata  = dGrant ? d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, read-return scoreboard,
// and one task per scenario.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        logic          ownerD;
        logic [DW-1:0] data;
    } sbEntry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic          c_ack;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_lock;
    logic          d_locked;
    logic          d_ack;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_strobe;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem   [256];
    logic [DW-1:0] model [256];
    sbEntry_t      sb[$];
    int            testsRun = 0;
    int            testsFailed = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_addr(c_addr), .c_ack(c_ack), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_locked(d_locked), .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_strobe(mem_strobe), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory with registered read data
    always @(posedge clk) begin
        if (mem_strobe) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Scoreboard: reads are queued at their ack and must come back on the next cycle
    always @(negedge clk) begin
        sbEntry_t e;
        if (reset) begin
            sb.delete();
        end else begin
            testsRun++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ownerD) begin
                    if (d_rvalid !== 1'b1 || c_rvalid !== 1'b0 || d_rdata !== e.data) begin
                        testsFailed++;
                        $display("[TB] FAIL d_read_return: d_rvalid=%b c_rvalid=%b d_rdata=%h expected d_rdata=%h",
                                 d_rvalid, c_rvalid, d_rdata, e.data);
                    end
                end else begin
                    if (c_rvalid !== 1'b1 || d_rvalid !== 1'b0 || c_rdata !== e.data) begin
                        testsFailed++;
                        $display("[TB] FAIL c_read_return: c_rvalid=%b d_rvalid=%b c_rdata=%h expected c_rdata=%h",
                                 c_rvalid, d_rvalid, c_rdata, e.data);
                    end
                end
            end else if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL spurious_rvalid: c_rvalid=%b d_rvalid=%b expected 0 0", c_rvalid, d_rvalid);
            end
            testsRun++;
            if ((c_ack && d_ack) || mem_strobe !== (c_ack | d_ack) || (mem_we && !d_ack)) begin
                testsFailed++;
                $display("[TB] FAIL grant_exclusive: c_ack=%b d_ack=%b mem_strobe=%b mem_we=%b",
                         c_ack, d_ack, mem_strobe, mem_we);
            end
            if (c_ack) sb.push_back('{ownerD: 1'b0, data: model[c_addr]});
            if (d_ack && !d_we) sb.push_back('{ownerD: 1'b1, data: model[d_addr]});
            if (d_ack && d_we) model[d_addr] = d_wdata;
        end
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; c_req = 1'b1; d_req = 1'b1; c_addr = 8'h10; d_addr = 8'h20;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            testsRun++;
            if ({c_ack, d_ack, mem_strobe, mem_we, c_rvalid, d_rvalid, d_locked} !== 7'b0 ||
                mem_addr !== 8'h00 || mem_wdata !== 8'h00 || c_rdata !== 8'h00 || d_rdata !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL reset_outputs: acks=%b%b strobe=%b we=%b rv=%b%b locked=%b addr=%h expected all 0",
                         c_ack, d_ack, mem_strobe, mem_we, c_rvalid, d_rvalid, d_locked, mem_addr);
            end
            nextCycle();
            c_req = 1'b0; d_req = 1'b0;
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        c_req = 1'b1; c_addr = 8'h10;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b1 || d_ack !== 1'b0 || mem_strobe !== 1'b1 || mem_addr !== 8'h10 || mem_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL c_read_grant: c_ack=%b strobe=%b addr=%h we=%b expected 1 1 10 0",
                     c_ack, mem_strobe, mem_addr, mem_we);
        end
        nextCycle();
        c_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL c_read_data: c_rvalid=%b c_rdata=%h expected 1 a5", c_rvalid, c_rdata);
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (c_rvalid !== 1'b0 || c_rdata !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL c_rdata_hold: c_rvalid=%b c_rdata=%h expected 0 a5", c_rvalid, c_rdata);
        end
        nextCycle();
    endtask

    task automatic test_write_read;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
        @(negedge clk);
        testsRun++;
        if (d_ack !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C || mem_addr !== 8'h20) begin
            testsFailed++;
            $display("[TB] FAIL d_write_grant: d_ack=%b we=%b wdata=%h addr=%h expected 1 1 3c 20",
                     d_ack, mem_we, mem_wdata, mem_addr);
        end
        nextCycle();
        d_we = 1'b0;
        @(negedge clk);
        testsRun++;
        if (d_rvalid !== 1'b0 || d_ack !== 1'b1 || mem_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL d_write_no_rvalid: d_rvalid=%b d_ack=%b we=%b expected 0 1 0", d_rvalid, d_ack, mem_we);
        end
        nextCycle();
        d_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if (d_rvalid !== 1'b1 || d_rdata !== 8'h3C) begin
            testsFailed++;
            $display("[TB] FAIL d_readback: d_rvalid=%b d_rdata=%h expected 1 3c", d_rvalid, d_rdata);
        end
        nextCycle();
    endtask

    task automatic test_round_robin;
        int cCount = 0;
        int dCount = 0;
        reset = 1'b1;
        nextCycle();
        reset = 1'b0; c_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_addr = 8'h40 + 8'(i);
            d_addr = 8'h60 + 8'(i);
            @(negedge clk);
            testsRun++;
            if (c_ack !== (i % 2 == 0) || d_ack !== (i % 2 == 1)) begin
                testsFailed++;
                $display("[TB] FAIL round_robin[%0d]: c_ack=%b d_ack=%b expected %b %b",
                         i, c_ack, d_ack, (i % 2 == 0), (i % 2 == 1));
            end
            if (c_ack) cCount++;
            if (d_ack) dCount++;
            nextCycle();
        end
        c_req = 1'b0; d_req = 1'b0;
        testsRun++;
        if (cCount != 4 || dCount != 4) begin
            testsFailed++;
            $display("[TB] FAIL round_robin_share: c=%0d d=%0d expected 4 4", cCount, dCount);
        end
        nextCycle();
    endtask

    task automatic test_lock;
        logic got = 1'b0;
        c_req = 1'b1; c_addr = 8'h11;
        nextCycle();
        c_addr = 8'h12; d_lock = 1'b1;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lock_c_in_flight: c_ack=%b expected 1", c_ack);
        end
        nextCycle();
        c_addr = 8'h13;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b0 || c_rvalid !== 1'b1 || d_locked !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lock_wait: c_ack=%b c_rvalid=%b d_locked=%b expected 0 1 0", c_ack, c_rvalid, d_locked);
        end
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            d_req = (k == 2 || k == 3); d_we = 1'b0; d_addr = 8'h20;
            @(negedge clk);
            testsRun++;
            if (c_ack !== 1'b0 || d_locked !== 1'b1 || d_ack !== d_req) begin
                testsFailed++;
                $display("[TB] FAIL locked[%0d]: c_ack=%b d_locked=%b d_ack=%b expected 0 1 %b",
                         k, c_ack, d_locked, d_ack, d_req);
            end
            nextCycle();
        end
        d_req = 1'b0; d_lock = 1'b0;
        for (int j = 0; j < 2 && !got; j++) begin
            @(negedge clk);
            got = c_ack;
            nextCycle();
            if (got) c_req = 1'b0;
        end
        c_req = 1'b0;
        testsRun++;
        if (!got) begin
            testsFailed++;
            $display("[TB] FAIL unlock_c_ack: c_ack seen=%b expected 1 within 2 cycles", got);
        end
        nextCycle();
    endtask

    task automatic test_reset_mid_read;
        c_req = 1'b1; c_addr = 8'h10;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_ack: c_ack=%b expected 1", c_ack);
        end
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (c_rvalid !== 1'b0 || c_ack !== 1'b0 || mem_strobe !== 1'b0 || c_rdata !== 8'h00 || d_locked !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_read: c_rvalid=%b c_ack=%b strobe=%b c_rdata=%h expected 0 0 0 00",
                     c_rvalid, c_ack, mem_strobe, c_rdata);
        end
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_ack: c_ack=%b expected 1", c_ack);
        end
        nextCycle();
        c_req = 1'b0;
        @(negedge clk);
        testsRun++;
        if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_read: c_rvalid=%b c_rdata=%h expected 1 a5", c_rvalid, c_rdata);
        end
        nextCycle();
    endtask

    task automatic test_max_wait;
        int run = 0;
        int maxRun = 0;
        int dAcks = 0;
        reset = 1'b1;
        nextCycle();
        reset = 1'b0; c_req = 1'b1; c_addr = 8'h30; d_lock = 1'b1;
        nextCycle();
        c_req = 1'b0;
        nextCycle();
        c_req = 1'b1; c_addr = 8'h31;
        nextCycle();
        d_lock = 1'b0;
        @(negedge clk);
        testsRun++;
        if (d_locked !== 1'b1 || c_ack !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL max_wait_locked: d_locked=%b c_ack=%b expected 1 0", d_locked, c_ack);
        end
        nextCycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h32;
        @(negedge clk);
        testsRun++;
        if (c_ack !== 1'b1 || d_ack !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL max_wait_override: c_ack=%b d_ack=%b expected 1 0", c_ack, d_ack);
        end
        nextCycle();
        for (int i = 0; i < 12; i++) begin
            c_addr = 8'(8'h70 + i);
            d_addr = 8'(8'h80 + i);
            @(negedge clk);
            if (c_ack) run = 0;
            else       run++;
            if (run > maxRun) maxRun = run;
            if (d_ack) dAcks++;
            nextCycle();
        end
        c_req = 1'b0; d_req = 1'b0;
        testsRun++;
        if (maxRun > 2 || dAcks == 0) begin
            testsFailed++;
            $display("[TB] FAIL max_wait_bound: longest C wait=%0d d_acks=%0d expected <=2 and >0", maxRun, dAcks);
        end
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'(i) ^ 8'h5A;
            model[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10] = 8'hA5; model[8'h10] = 8'hA5;
        reset = 1'b1; c_req = 1'b0; c_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_lock = 1'b0;
        nextCycle();
        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_lock();
        test_reset_mid_read();
        test_max_wait();
        nextCycle();
        nextCycle();
        testsRun++;
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
